// File: rtl/loadstore_pkg.sv
// Shared definitions for the load/store control unit: state encoding,
// accepted opcodes/funct3 and RISC-V instruction field positions.
package loadstore_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      LD_MEM = 3'd2,
      LD_WB  = 3'd3,
      ST_WR  = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [2:0] FUNCT3_D  = 3'b011;

   localparam int unsigned OPC_LSB    = 0;
   localparam int unsigned RD_LSB     = 7;
   localparam int unsigned F3_LSB     = 12;
   localparam int unsigned RS1_LSB    = 15;
   localparam int unsigned RS2_LSB    = 20;
   localparam int unsigned IMM_HI_LSB = 25;

endpackage

// File: rtl/loadstore_decoder.sv
// Combinational field extraction and legality check for the latched LD/SD word.
import loadstore_pkg::*;

module loadstore_decoder (
   input  logic [31:0] instr,
   output logic        is_load,
   output logic        is_store,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [4:0]  imm5,
   output logic        illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [11:0] imm12;

   always_comb begin
      opcode   = instr[OPC_LSB +: 7];
      funct3   = instr[F3_LSB +: 3];
      rs1      = instr[RS1_LSB +: 5];
      rs2      = instr[RS2_LSB +: 5];
      rd       = instr[RD_LSB +: 5];
      is_load  = (opcode == OPC_LOAD);
      is_store = (opcode == OPC_STORE);
      // Store splits its immediate around rd; anything else uses the I-type layout.
      if (is_store) begin
         imm12 = {instr[IMM_HI_LSB +: 7], instr[RD_LSB +: 5]};
      end else begin
         imm12 = instr[RS2_LSB +: 12];
      end
      imm5    = imm12[4:0];
      illegal = !(is_load || is_store) || (funct3 != FUNCT3_D) || (imm12[11:5] != 7'd0);
   end

endmodule

// File: rtl/loadstore_uc.sv
// Load/store control unit: accepts one LD/SD per handshake and sequences the
// register-bank/memory addresses and write strobes of the datapath.
import loadstore_pkg::*;

// state  | meaning
// IDLE   | ready for a new instruction
// DECODE | Rb/Ra/OFFSET driven from latched word, legality checked
// LD_MEM | memory read address stable, Rw driven
// LD_WB  | register-bank write (suppressed for rd == x0)
// ST_WR  | memory write
// DONE   | completion pulse, illegal flagged if rejected
module loadstore_uc (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [4:0]  Ra,
   output logic [4:0]  Rb,
   output logic [4:0]  Rw,
   output logic [4:0]  OFFSET,
   output logic        WE_reg,
   output logic        WE_mem,
   output logic        busy,
   output logic        done,
   output logic        illegal
);

   state_t      state_q, state_d;
   logic [31:0] instr_q;
   logic        ready_en_q;
   logic [4:0]  ra_q, rb_q, rw_q, off_q;
   logic        transfer;

   logic        dec_is_load, dec_is_store, dec_illegal;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd, dec_imm5;

   loadstore_decoder u_dec (
      .instr    (instr_q),
      .is_load  (dec_is_load),
      .is_store (dec_is_store),
      .rs1      (dec_rs1),
      .rs2      (dec_rs2),
      .rd       (dec_rd),
      .imm5     (dec_imm5),
      .illegal  (dec_illegal)
   );

   // Ready is held off until the first clock edge after reset release.
   assign instr_ready = (state_q == IDLE) && ready_en_q;
   assign busy        = (state_q != IDLE);
   assign transfer    = instr_valid && instr_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         instr_q    <= '0;
         ready_en_q <= 1'b0;
         ra_q       <= '0;
         rb_q       <= '0;
         rw_q       <= '0;
         off_q      <= '0;
      end else begin
         ready_en_q <= 1'b1;
         state_q    <= state_d;
         if (transfer) begin
            instr_q <= instr;
         end
         if (state_q == DECODE) begin
            rb_q  <= dec_rs1;
            off_q <= dec_imm5;
            if (dec_is_store) begin
               ra_q <= dec_rs2;
            end
         end
         if (state_q == LD_MEM) begin
            rw_q <= dec_rd;
         end
      end
   end

   // Address outputs pass the decoded field through in the cycle it is first
   // needed and then hold the registered copy.
   always_comb begin
      state_d = state_q;
      Ra      = ra_q;
      Rb      = rb_q;
      Rw      = rw_q;
      OFFSET  = off_q;
      WE_reg  = 1'b0;
      WE_mem  = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
      case (state_q)
         IDLE: begin
            if (transfer) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            Rb     = dec_rs1;
            OFFSET = dec_imm5;
            if (dec_is_store) begin
               Ra = dec_rs2;
            end
            if (dec_illegal) begin
               state_d = DONE;
            end else if (dec_is_load) begin
               state_d = LD_MEM;
            end else begin
               state_d = ST_WR;
            end
         end
         LD_MEM: begin
            Rw      = dec_rd;
            state_d = LD_WB;
         end
         LD_WB: begin
            WE_reg  = (dec_rd != 5'd0) && !rst;
            state_d = DONE;
         end
         ST_WR: begin
            WE_mem  = !rst;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            illegal = dec_illegal;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_loadstore_uc.sv
// Randomized scoreboard bench for loadstore_uc: driver pushes expected
// per-instruction behaviour, a negedge monitor checks every cycle against it.
module tb_loadstore_uc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready;
   logic [4:0]  Ra, Rb, Rw, OFFSET;
   logic        WE_reg, WE_mem, busy, done, illegal;

   loadstore_uc dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .Ra          (Ra),
      .Rb          (Rb),
      .Rw          (Rw),
      .OFFSET      (OFFSET),
      .WE_reg      (WE_reg),
      .WE_mem      (WE_mem),
      .busy        (busy),
      .done        (done),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t;
      int lat;
      bit ill;
      bit ld;
      bit st;
      int rs1;
      int rs2;
      int rd;
      int off;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   last_t = 0;
   int   last_lat = 0;
   bit   last_hold = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference: instruction meaning straight from the ISA rules.
   function automatic exp_t model(input logic [31:0] w, input int t);
      exp_t        e;
      int unsigned u;
      int          opc, f3, hi7;
      u     = w;
      opc   = int'(u & 32'h7f);
      f3    = int'((u >> 12) & 32'h7);
      hi7   = int'((u >> 25) & 32'h7f);
      e.t   = t;
      e.ld  = (opc == 3);
      e.st  = (opc == 35);
      e.ill = !(e.ld || e.st) || (f3 != 3) || (hi7 != 0);
      e.rs1 = int'((u >> 15) & 32'h1f);
      e.rs2 = int'((u >> 20) & 32'h1f);
      e.rd  = int'((u >> 7) & 32'h1f);
      e.off = e.st ? int'((u >> 7) & 32'h1f) : int'((u >> 20) & 32'h1f);
      e.lat = e.ill ? 2 : (e.ld ? 4 : 3);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0]  r1, r2, rd, off;
      logic [2:0]  f3;
      logic [6:0]  hi;
      logic [31:0] w;
      int          k;
      r1  = 5'($urandom);
      r2  = 5'($urandom);
      rd  = 5'($urandom);
      off = 5'($urandom);
      k   = $urandom_range(0, 11);
      if (k <= 4) begin
         w = {7'd0, off, r1, 3'b011, rd, 7'b0000011};
      end else if (k <= 8) begin
         w = {7'd0, r2, r1, 3'b011, off, 7'b0100011};
      end else if (k == 9) begin
         f3 = 3'($urandom_range(0, 7));
         if (f3 == 3'b011) f3 = 3'b010;
         w = {7'd0, off, r1, f3, rd, 7'b0000011};
      end else if (k == 10) begin
         hi = 7'($urandom_range(1, 127));
         w = {hi, r2, r1, 3'b011, off, 7'b0100011};
      end else begin
         w = $urandom;
      end
      return w;
   endfunction

   // Called on a negedge; returns on the negedge after the transfer edge.
   task automatic send(input logic [31:0] w, input bit hold);
      int   guard;
      exp_t e;
      guard       = 0;
      instr       = w;
      instr_valid = 1'b1;
      while (!instr_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!instr_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: instr_ready stayed 0 for %0d cycles, required 1", guard);
         instr_valid = 1'b0;
         last_hold   = 0;
         return;
      end
      e = model(w, cyc);
      if (last_hold) chk("throughput_gap", cyc - last_t, last_lat + 1);
      sb.push_back(e);
      last_t    = cyc;
      last_lat  = e.lat;
      last_hold = hold;
      @(negedge clk);
      if (!hold) begin
         instr_valid = 1'b0;
         instr       = $urandom;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   rel;
      if (!rst) begin
         if (WE_reg && WE_mem) chk("strobe_overlap", 1, 0);
         if (sb.size() == 0) begin
            chk("quiet_strobes_done", {WE_reg, WE_mem, done}, 3'b000);
         end else begin
            e   = sb[0];
            rel = cyc - e.t;
            if (rel < 1) begin
               chk("quiet_strobes_done", {WE_reg, WE_mem, done}, 3'b000);
            end else begin
               chk("busy", busy, 1);
               chk("we_reg", WE_reg, (!e.ill && e.ld && e.rd != 0 && rel == 3));
               chk("we_mem", WE_mem, (!e.ill && e.st && rel == 2));
               chk("done", done, (rel == e.lat));
               if (rel == 1 && !e.ill) begin
                  chk("rb_decode", Rb, e.rs1);
                  chk("offset_decode", OFFSET, e.off);
                  if (e.st) chk("ra_decode", Ra, e.rs2);
               end
               if ((rel == 2 || rel == 3) && !e.ill && e.ld) chk("rw_load", Rw, e.rd);
               if (rel >= e.lat) begin
                  chk("illegal", illegal, e.ill);
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int guard;
      #12;
      chk("reset_outputs", {Ra, Rb, Rw, OFFSET, WE_reg, WE_mem, busy, done, illegal}, 29'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("ready_after_reset", instr_ready, 1);
      @(negedge clk);

      // Reset in the middle of a store write.
      send(32'h0071B223, 1'b0);
      @(negedge clk);
      #2;
      chk("we_mem_before_rst", WE_mem, 1);
      rst = 1'b1;
      #1;
      chk("we_mem_drops_with_rst", WE_mem, 0);
      chk("done_during_rst", done, 0);
      chk("busy_during_rst", busy, 0);
      sb.delete();
      last_hold = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("ready_after_midrst", instr_ready, 1);
      @(negedge clk);

      send(32'h00813283, 1'b0);   // ld x5,8(x2)
      repeat (6) @(negedge clk);
      send(32'h0071B223, 1'b0);   // sd x7,4(x3)
      repeat (5) @(negedge clk);
      send(32'h04013283, 1'b0);   // offset 64
      repeat (3) @(negedge clk);
      send(32'h00000013, 1'b0);   // addi
      repeat (3) @(negedge clk);
      send(32'h00813003, 1'b0);   // ld x0,8(x2)
      repeat (6) @(negedge clk);
      send(32'h00813283, 1'b1);   // back-to-back load then store
      send(32'h0071B223, 1'b0);
      repeat (5) @(negedge clk);

      for (int i = 0; i < 250; i++) begin
         bit hold;
         hold = ($urandom_range(0, 2) != 0);
         send(rand_instr(), hold);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      instr_valid = 1'b0;

      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d instructions outstanding, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
